// File: rtl/proc_io_device.sv
// Byte-wide processor I/O peripheral: host stream <-> processor four-phase in/out handshakes via two FIFOs.
// Optional IO_DEV_LOOPBACK_EN adds a `loopback` input routing processor output bytes into the inbound FIFO.
module proc_io_device #(
  parameter int unsigned width    = 8,
  parameter int unsigned depth    = 4,
  parameter int unsigned ptrWidth = 2
) (
  input  logic                clk,
  input  logic                reset,
`ifdef IO_DEV_LOOPBACK_EN
  input  logic                loopback,
`endif
  input  logic [width-1:0]    hostInData,
  input  logic                hostInValid,
  output logic                hostInReady,
  output logic [width-1:0]    hostOutData,
  output logic                hostOutValid,
  input  logic                hostOutReady,
  output logic [width-1:0]    procIn,
  output logic                procInDataReady,
  input  logic                procInACK,
  input  logic [width-1:0]    procOut,
  input  logic                procOutDataReady,
  output logic                procOutACK,
  output logic [ptrWidth:0]   inCount,
  output logic [ptrWidth:0]   outCount
);

  typedef enum logic [1:0] {T_IDLE, T_PRESENT, T_WAITLOW} tstate_e;
  typedef enum logic       {R_IDLE, R_ACK} rstate_e;

  tstate_e t_state_q, t_state_d;
  rstate_e r_state_q, r_state_d;

  logic [width-1:0]    in_mem_q  [depth];
  logic [width-1:0]    out_mem_q [depth];
  logic [ptrWidth-1:0] in_wr_q, in_rd_q, out_wr_q, out_rd_q;
  logic [ptrWidth:0]   in_cnt_q, out_cnt_q;
  logic [width-1:0]    proc_in_q, proc_in_d;

  logic lb_sel;
  logic in_full, in_empty, out_full, out_empty;
  logic host_push, lb_push, in_push, in_pop;
  logic out_push, out_pop;
  logic [width-1:0] in_wdata;

`ifdef IO_DEV_LOOPBACK_EN
  assign lb_sel = loopback;
`else
  assign lb_sel = 1'b0;
`endif

  // depth is a power of two, so the count MSB alone marks a full FIFO
  assign in_full   = in_cnt_q[ptrWidth];
  assign out_full  = out_cnt_q[ptrWidth];
  assign in_empty  = (in_cnt_q == '0);
  assign out_empty = (out_cnt_q == '0);

  assign hostInReady  = !in_full && !lb_sel;
  assign hostOutValid = !out_empty;
  assign hostOutData  = out_mem_q[out_rd_q];
  assign inCount      = in_cnt_q;
  assign outCount     = out_cnt_q;

  assign procIn          = proc_in_q;
  assign procInDataReady = (t_state_q == T_PRESENT);
  assign procOutACK      = (r_state_q == R_ACK);

  assign host_push = hostInValid && hostInReady;
  assign in_push   = host_push || lb_push;
  assign in_wdata  = lb_push ? procOut : hostInData;
  assign out_pop   = hostOutValid && hostOutReady;

  always_comb begin
    t_state_d = t_state_q;
    proc_in_d = proc_in_q;
    in_pop    = 1'b0;
    case (t_state_q)
      T_IDLE: begin
        if (!in_empty) begin
          proc_in_d = in_mem_q[in_rd_q];
          t_state_d = T_PRESENT;
        end
      end
      T_PRESENT: begin
        if (procInACK) begin
          in_pop    = !in_empty;
          t_state_d = T_WAITLOW;
        end
      end
      T_WAITLOW: begin
        if (!procInACK) t_state_d = T_IDLE;
      end
      default: t_state_d = T_IDLE;
    endcase
  end

  // The write happens only on the R_IDLE->R_ACK step, so a long DataReady stores one byte
  always_comb begin
    r_state_d = r_state_q;
    out_push  = 1'b0;
    lb_push   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (procOutDataReady) begin
          if (lb_sel) begin
            if (!in_full) begin
              lb_push   = 1'b1;
              r_state_d = R_ACK;
            end
          end else if (!out_full) begin
            out_push  = 1'b1;
            r_state_d = R_ACK;
          end
        end
      end
      R_ACK: begin
        if (!procOutDataReady) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_state_q <= T_IDLE;
      r_state_q <= R_IDLE;
      proc_in_q <= '0;
    end else begin
      t_state_q <= t_state_d;
      r_state_q <= r_state_d;
      proc_in_q <= proc_in_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < depth; i++) in_mem_q[i] <= '0;
      in_wr_q  <= '0;
      in_rd_q  <= '0;
      in_cnt_q <= '0;
    end else begin
      if (in_push) begin
        in_mem_q[in_wr_q] <= in_wdata;
        in_wr_q           <= in_wr_q + 1'b1;
      end
      if (in_pop) in_rd_q <= in_rd_q + 1'b1;
      case ({in_push, in_pop})
        2'b10:   in_cnt_q <= in_cnt_q + 1'b1;
        2'b01:   in_cnt_q <= in_cnt_q - 1'b1;
        default: in_cnt_q <= in_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < depth; i++) out_mem_q[i] <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (out_push) begin
        out_mem_q[out_wr_q] <= procOut;
        out_wr_q            <= out_wr_q + 1'b1;
      end
      if (out_pop) out_rd_q <= out_rd_q + 1'b1;
      case ({out_push, out_pop})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_io_device.sv
// Directed bench for proc_io_device with scoreboard queues for both directions.
module tb_proc_io_device;

  logic       clk;
  logic       reset;
`ifdef IO_DEV_LOOPBACK_EN
  logic       loopback;
`endif
  logic [7:0] hostInData;
  logic       hostInValid;
  logic       hostInReady;
  logic [7:0] hostOutData;
  logic       hostOutValid;
  logic       hostOutReady;
  logic [7:0] procIn;
  logic       procInDataReady;
  logic       procInACK;
  logic [7:0] procOut;
  logic       procOutDataReady;
  logic       procOutACK;
  logic [2:0] inCount;
  logic [2:0] outCount;

  int errors = 0;
  int checks = 0;
  int in_exp = 0;
  logic [7:0] q_in[$];
  logic [7:0] q_out[$];

  proc_io_device #(.width(8), .depth(4), .ptrWidth(2)) dut (
    .clk              (clk),
    .reset            (reset),
`ifdef IO_DEV_LOOPBACK_EN
    .loopback         (loopback),
`endif
    .hostInData       (hostInData),
    .hostInValid      (hostInValid),
    .hostInReady      (hostInReady),
    .hostOutData      (hostOutData),
    .hostOutValid     (hostOutValid),
    .hostOutReady     (hostOutReady),
    .procIn           (procIn),
    .procInDataReady  (procInDataReady),
    .procInACK        (procInACK),
    .procOut          (procOut),
    .procOutDataReady (procOutDataReady),
    .procOutACK       (procOutACK),
    .inCount          (inCount),
    .outCount         (outCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_push(input logic [7:0] b);
    logic rdy_exp;
    rdy_exp = (in_exp < 4);
    hostInData  = b;
    hostInValid = 1'b1;
    chk("hostInReady_pre", 32'(hostInReady), 32'(rdy_exp));
    if (in_exp < 4) begin
      q_in.push_back(b);
      in_exp++;
    end
    tick();
    hostInValid = 1'b0;
    chk("inCount_push", 32'(inCount), 32'(in_exp));
  endtask

  task automatic proc_take();
    logic [7:0] exp;
    int n;
    n = 0;
    while (!procInDataReady && n < 20) begin
      tick();
      n++;
    end
    chk("offer_seen", 32'(procInDataReady), 32'd1);
    exp = (q_in.size() > 0) ? q_in.pop_front() : 8'hxx;
    chk("procIn", 32'(procIn), 32'(exp));
    repeat (2) begin
      tick();
      chk("procIn_hold", 32'(procIn), 32'(exp));
      chk("inDR_hold", 32'(procInDataReady), 32'd1);
    end
    procInACK = 1'b1;
    tick();
    if (in_exp > 0) in_exp--;
    chk("inDR_after_ack", 32'(procInDataReady), 32'd0);
    chk("inCount_pop", 32'(inCount), 32'(in_exp));
    procInACK = 1'b0;
    tick();
    chk("inDR_idle_gap", 32'(procInDataReady), 32'd0);
  endtask

  task automatic proc_send(input logic [7:0] b, input int hold);
    int n;
    int cnt_after;
    procOut          = b;
    procOutDataReady = 1'b1;
    q_out.push_back(b);
    n = 0;
    while (!procOutACK && n < 20) begin
      tick();
      n++;
    end
    chk("outACK_rise", 32'(procOutACK), 32'd1);
    chk("hostOutValid_send", 32'(hostOutValid), 32'd1);
    cnt_after = int'(outCount);
    repeat (hold) tick();
    chk("outCount_one_write", 32'(outCount), 32'(cnt_after));
    procOutDataReady = 1'b0;
    tick();
    chk("outACK_fall", 32'(procOutACK), 32'd0);
  endtask

  initial begin
    reset            = 1'b0;
`ifdef IO_DEV_LOOPBACK_EN
    loopback         = 1'b0;
`endif
    hostInData       = '0;
    hostInValid      = 1'b0;
    hostOutReady     = 1'b0;
    procInACK        = 1'b0;
    procOut          = '0;
    procOutDataReady = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_procIn", 32'(procIn), 32'd0);
    chk("rst_inDR", 32'(procInDataReady), 32'd0);
    chk("rst_outACK", 32'(procOutACK), 32'd0);
    chk("rst_hostInReady", 32'(hostInReady), 32'd1);
    chk("rst_hostOutValid", 32'(hostOutValid), 32'd0);
    chk("rst_hostOutData", 32'(hostOutData), 32'd0);
    chk("rst_inCount", 32'(inCount), 32'd0);
    chk("rst_outCount", 32'(outCount), 32'd0);
    reset = 1'b1;
    tick();

    // two bytes, offer latency from empty
    host_push(8'hA5);
    chk("offer_latency_n", 32'(procInDataReady), 32'd0);
    host_push(8'h3C);
    chk("offer_latency_n1", 32'(procInDataReady), 32'd1);
    proc_take();
    proc_take();
    chk("inCount_drained", 32'(inCount), 32'd0);

    // overfill: fifth push ignored, pointers wrap
    for (int i = 0; i < 5; i++) host_push(8'h50 + 8'(i));
    chk("inFull_ready", 32'(hostInReady), 32'd0);
    chk("inFull_count", 32'(inCount), 32'd4);
    repeat (4) proc_take();
    chk("in_scoreboard_empty", 32'(q_in.size()), 32'd0);
    chk("hostInReady_drained", 32'(hostInReady), 32'd1);

    // outbound fill and stall
    proc_send(8'h11, 3);
    proc_send(8'h12, 0);
    proc_send(8'h13, 0);
    proc_send(8'h14, 0);
    chk("outCount_full", 32'(outCount), 32'd4);
    procOut          = 8'h15;
    procOutDataReady = 1'b1;
    repeat (3) begin
      tick();
      chk("outACK_stall", 32'(procOutACK), 32'd0);
    end
    chk("outCount_stall", 32'(outCount), 32'd4);
    chk("hostOutData_head", 32'(hostOutData), 32'(q_out.pop_front()));
    hostOutReady = 1'b1;
    tick();
    hostOutReady = 1'b0;
    chk("outCount_after_pop", 32'(outCount), 32'd3);
    tick();
    chk("outACK_unstall", 32'(procOutACK), 32'd1);
    chk("outCount_refill", 32'(outCount), 32'd4);
    q_out.push_back(8'h15);
    procOutDataReady = 1'b0;
    tick();
    chk("outACK_fall_15", 32'(procOutACK), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("hostOutValid_drain", 32'(hostOutValid), 32'd1);
      chk("hostOutData_drain", 32'(hostOutData), 32'(q_out.pop_front()));
      hostOutReady = 1'b1;
      tick();
      hostOutReady = 1'b0;
    end
    chk("hostOutValid_empty", 32'(hostOutValid), 32'd0);
    chk("outCount_empty", 32'(outCount), 32'd0);

    // reset in T_PRESENT and R_ACK
    host_push(8'h77);
    host_push(8'h78);
    begin
      int n;
      n = 0;
      while (!procInDataReady && n < 20) begin
        tick();
        n++;
      end
    end
    chk("pre_rst_inDR", 32'(procInDataReady), 32'd1);
    procOut          = 8'h99;
    procOutDataReady = 1'b1;
    tick();
    chk("pre_rst_outACK", 32'(procOutACK), 32'd1);
    chk("pre_rst_outCount", 32'(outCount), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_inDR", 32'(procInDataReady), 32'd0);
    chk("arst_outACK", 32'(procOutACK), 32'd0);
    chk("arst_inCount", 32'(inCount), 32'd0);
    chk("arst_outCount", 32'(outCount), 32'd0);
    chk("arst_hostOutValid", 32'(hostOutValid), 32'd0);
    chk("arst_hostOutData", 32'(hostOutData), 32'd0);
    chk("arst_procIn", 32'(procIn), 32'd0);
    procOutDataReady = 1'b0;
    tick();
    reset = 1'b1;
    q_in.delete();
    q_out.delete();
    in_exp = 0;
    tick();
    host_push(8'h42);
    proc_take();

`ifdef IO_DEV_LOOPBACK_EN
    loopback = 1'b1;
    #1;
    chk("lb_hostInReady", 32'(hostInReady), 32'd0);
    procOut          = 8'h5A;
    procOutDataReady = 1'b1;
    begin
      int n;
      n = 0;
      while (!procOutACK && n < 20) begin
        tick();
        n++;
      end
    end
    chk("lb_outACK", 32'(procOutACK), 32'd1);
    chk("lb_outCount", 32'(outCount), 32'd0);
    procOutDataReady = 1'b0;
    tick();
    q_in.push_back(8'h5A);
    in_exp = 1;
    proc_take();
    chk("lb_outCount_end", 32'(outCount), 32'd0);
    loopback = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
